rv32f_mem_arbiter: RTL and testbench

RV32F_MEM_ARBITER -- requirements
Module: rv32f_mem_arbiter

---
 rtl/rv32f_mem_arbiter_if.sv | 53 +++++
 rtl/rv32f_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_rv32f_mem_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32f_mem_arbiter_if.sv
// ============================================================================
// Module : rv32f_mem_arbiter_if
// Brief  : Integer LSU, RV32F LSU and shared data-memory signal bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32f_mem_arbiter_if;
    logic        int_req;
    logic        int_wen;
    logic [31:0] int_addr;
    logic [31:0] int_wdata;
    logic        int_done;
    logic        int_err;
    logic [31:0] int_rdata;

    logic        fp_req;
    logic        fp_wen;
    logic [31:0] fp_addr;
    logic [31:0] fp_wdata;
    logic        fp_done;
    logic        fp_err;
    logic [31:0] fp_rdata;

    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy;

    // Arbiter side
    modport slave (
        input  int_req, int_wen, int_addr, int_wdata,
        output int_done, int_err, int_rdata,
        input  fp_req, fp_wen, fp_addr, fp_wdata,
        output fp_done, fp_err, fp_rdata,
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_busy
    );

    // Requester and memory side
    modport master (
        output int_req, int_wen, int_addr, int_wdata,
        input  int_done, int_err, int_rdata,
        output fp_req, fp_wen, fp_addr, fp_wdata,
        input  fp_done, fp_err, fp_rdata,
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_busy
    );
endinterface

`default_nettype wire

// File: rtl/rv32f_mem_arbiter.sv
// ============================================================================
// Module : rv32f_mem_arbiter
// Brief  : Round-robin arbiter sharing one data memory between int and FP LSUs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32f_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    rv32f_mem_arbiter_if.slave bus
);

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_fp;
    logic        r_owner_fp;
    logic        r_wen;
    logic        r_aerr;
    logic        r_active;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [7:0]  r_cnt;
    logic        r_int_done;
    logic        r_int_err;
    logic        r_fp_done;
    logic        r_fp_err;

    logic        w_grant_any;
    logic        w_grant_fp;
    logic        w_sel_wen;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_misalign;
    logic        w_exit;
    logic        w_ok;

    // On a tie the requester that did not win last time is granted.
    assign w_grant_any = bus.int_req | bus.fp_req;
    assign w_grant_fp  = bus.fp_req & (~bus.int_req | ~r_last_fp);
    assign w_sel_wen   = w_grant_fp ? bus.fp_wen   : bus.int_wen;
    assign w_sel_addr  = w_grant_fp ? bus.fp_addr  : bus.int_addr;
    assign w_sel_wdata = w_grant_fp ? bus.fp_wdata : bus.int_wdata;
    assign w_misalign  = w_grant_fp & (bus.fp_addr[1:0] != 2'b00);

    assign w_exit = r_aerr | ~bus.mem_busy | (r_cnt == c_CNT_LAST);
    assign w_ok   = ~r_aerr & ~bus.mem_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_fp  <= 1'b1;
            r_owner_fp <= 1'b0;
            r_wen      <= 1'b0;
            r_aerr     <= 1'b0;
            r_active   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_int_done <= 1'b0;
            r_int_err  <= 1'b0;
            r_fp_done  <= 1'b0;
            r_fp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_owner_fp <= w_grant_fp;
                        r_last_fp  <= w_grant_fp;
                        r_wen      <= w_sel_wen;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_cnt      <= '0;
                        r_aerr     <= w_misalign;
                        r_active   <= ~w_misalign;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A misaligned FP access spends this cycle without strobes.
                    if (w_exit) begin
                        r_active   <= 1'b0;
                        r_aerr     <= 1'b0;
                        r_int_done <= ~r_owner_fp &  w_ok;
                        r_int_err  <= ~r_owner_fp & ~w_ok;
                        r_fp_done  <=  r_owner_fp &  w_ok;
                        r_fp_err   <=  r_owner_fp & ~w_ok;
                        r_rdata    <= (w_ok & ~r_wen) ? bus.mem_rdata : 32'h0;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_int_done <= 1'b0;
                    r_int_err  <= 1'b0;
                    r_fp_done  <= 1'b0;
                    r_fp_err   <= 1'b0;
                    r_rdata    <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_ren   = r_active & ~r_wen;
    assign bus.mem_wen   = r_active &  r_wen;
    assign bus.mem_addr  = r_active ? r_addr  : 32'h0;
    assign bus.mem_wdata = r_active ? r_wdata : 32'h0;

    // r_rdata is zero outside RESP, so gating by owner is sufficient.
    assign bus.int_done  = r_int_done;
    assign bus.int_err   = r_int_err;
    assign bus.int_rdata = r_owner_fp ? 32'h0 : r_rdata;
    assign bus.fp_done   = r_fp_done;
    assign bus.fp_err    = r_fp_err;
    assign bus.fp_rdata  = r_owner_fp ? r_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_rv32f_mem_arbiter.sv
// ============================================================================
// Module : tb_rv32f_mem_arbiter
// Brief  : Self-checking bench: vector table, scoreboard and corner sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32f_mem_arbiter;

    localparam int c_TIMEOUT = 4;

    logic clk;
    logic rst_n;
    logic use_fn;
    logic [31:0] mdata;

    rv32f_mem_arbiter_if bus ();

    rv32f_mem_arbiter #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = use_fn ? (bus.mem_addr ^ 32'h5A5A_0000) : mdata;

    typedef struct {
        bit          fp;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          busy;
        logic [31:0] mdata;
        bit          drop;
        bit          done;
        bit          err;
        logic [31:0] rdata;
        int          strobes;
        int          lat;
    } vec_t;

    typedef struct {
        bit          fp;
        bit          done;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs [10];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_exp(input bit fp, input bit done, input bit err, input logic [31:0] rd);
        exp_t e;
        e.fp = fp; e.done = done; e.err = err; e.rdata = rd;
        sb_q.push_back(e);
    endfunction

    // Scoreboard monitor and per-cycle invariants
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_ren && bus.mem_wen)
            chk("both_strobes", 32'd1, 32'd0);
        if (!bus.mem_ren && !bus.mem_wen) begin
            chk("idle_mem_addr", bus.mem_addr, 32'h0);
            chk("idle_mem_wdata", bus.mem_wdata, 32'h0);
        end
        if (bus.int_done || bus.int_err || bus.fp_done || bus.fp_err) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("int_done",  {31'b0, bus.int_done}, {31'b0, ~e.fp & e.done});
                chk("int_err",   {31'b0, bus.int_err},  {31'b0, ~e.fp & e.err});
                chk("fp_done",   {31'b0, bus.fp_done},  {31'b0,  e.fp & e.done});
                chk("fp_err",    {31'b0, bus.fp_err},   {31'b0,  e.fp & e.err});
                chk("int_rdata", bus.int_rdata, e.fp ? 32'h0 : e.rdata);
                chk("fp_rdata",  bus.fp_rdata,  e.fp ? e.rdata : 32'h0);
            end
        end
    end

    task automatic drop_req(input bit fp);
        if (fp) bus.fp_req = 1'b0;
        else    bus.int_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int strobes = 0;
        int lat = 0;
        bit fin = 1'b0;
        @(negedge clk);
        bus.int_req = 1'b0;
        bus.fp_req  = 1'b0;
        if (v.fp) begin
            bus.fp_req = 1'b1; bus.fp_wen = v.wen; bus.fp_addr = v.addr; bus.fp_wdata = v.wdata;
        end else begin
            bus.int_req = 1'b1; bus.int_wen = v.wen; bus.int_addr = v.addr; bus.int_wdata = v.wdata;
        end
        use_fn = 1'b0;
        mdata = v.mdata;
        bus.mem_busy = 1'b1;
        push_exp(v.fp, v.done, v.err, v.rdata);
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(negedge clk);
            if (bus.mem_ren || bus.mem_wen) begin
                strobes++;
                chk("strobe_addr",  bus.mem_addr,  v.addr);
                chk("strobe_wdata", bus.mem_wdata, v.wdata);
                chk("strobe_wen",   {31'b0, bus.mem_wen}, {31'b0, v.wen});
                bus.mem_busy = (strobes <= v.busy);
                if (v.drop) drop_req(v.fp);
            end
            if (v.fp ? (bus.fp_done || bus.fp_err) : (bus.int_done || bus.int_err)) begin
                lat = c;
                fin = 1'b1;
                drop_req(v.fp);
            end
        end
        if (!fin) begin
            chk("txn_timeout", 32'd1, 32'd0);
            drop_req(v.fp);
        end
        chk("strobe_cycles", strobes, v.strobes);
        chk("latency", lat, v.lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ni;
        int nf;
        //           fp wen addr          wdata         busy mdata         drop done err rdata         str lat
        vecs[0] = '{1, 0, 32'h0000_0100, 32'h0000_0000, 2, 32'h3F80_0000, 0, 1, 0, 32'h3F80_0000, 3, 4};
        vecs[1] = '{1, 1, 32'h0000_0102, 32'h1111_1111, 0, 32'h0000_0000, 0, 0, 1, 32'h0000_0000, 0, 2};
        vecs[2] = '{1, 1, 32'h0000_0200, 32'h4049_0FDB, 9, 32'h0000_0000, 0, 0, 1, 32'h0000_0000, 4, 5};
        vecs[3] = '{0, 0, 32'h0000_0103, 32'h0000_0000, 0, 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF, 1, 2};
        vecs[4] = '{0, 1, 32'h0000_0080, 32'h1234_5678, 1, 32'hFFFF_FFFF, 0, 1, 0, 32'h0000_0000, 2, 3};
        vecs[5] = '{1, 0, 32'h0000_0040, 32'h0000_0000, 1, 32'hC000_0000, 1, 1, 0, 32'hC000_0000, 2, 3};
        vecs[6] = '{0, 0, 32'h0000_0010, 32'h0000_0000, 3, 32'h0000_0001, 0, 1, 0, 32'h0000_0001, 4, 5};
        vecs[7] = '{0, 0, 32'h0000_0014, 32'h0000_0000, 4, 32'hAAAA_5555, 0, 0, 1, 32'h0000_0000, 4, 5};
        vecs[8] = '{1, 1, 32'h0000_0104, 32'h3F00_0000, 0, 32'h7777_7777, 0, 1, 0, 32'h0000_0000, 1, 2};
        vecs[9] = '{1, 0, 32'h0000_0001, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 32'h0000_0000, 0, 2};

        rst_n = 1'b0;
        use_fn = 1'b0;
        mdata = 32'h0;
        bus.int_req = 1'b0; bus.int_wen = 1'b0; bus.int_addr = '0; bus.int_wdata = '0;
        bus.fp_req  = 1'b0; bus.fp_wen  = 1'b0; bus.fp_addr  = '0; bus.fp_wdata  = '0;
        bus.mem_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_ren",   {31'b0, bus.mem_ren},  32'd0);
        chk("rst_mem_wen",   {31'b0, bus.mem_wen},  32'd0);
        chk("rst_int_done",  {31'b0, bus.int_done}, 32'd0);
        chk("rst_fp_err",    {31'b0, bus.fp_err},   32'd0);
        chk("rst_int_rdata", bus.int_rdata, 32'h0);
        chk("rst_fp_rdata",  bus.fp_rdata,  32'h0);
        rst_n = 1'b1;

        // Simultaneous requests held continuously: int wins first tie, then strict alternation
        @(negedge clk);
        bus.int_req = 1'b1; bus.int_wen = 1'b0; bus.int_addr = 32'h0000_0200;
        bus.fp_req  = 1'b1; bus.fp_wen  = 1'b0; bus.fp_addr  = 32'h0000_0300;
        use_fn = 1'b1;
        bus.mem_busy = 1'b0;
        push_exp(0, 1, 0, 32'h5A5A_0200);
        push_exp(1, 1, 0, 32'h5A5A_0300);
        push_exp(0, 1, 0, 32'h5A5A_0200);
        push_exp(1, 1, 0, 32'h5A5A_0300);
        ni = 0;
        nf = 0;
        for (int c = 0; c < 60 && (bus.int_req || bus.fp_req); c++) begin
            @(negedge clk);
            if (bus.int_done) begin ni++; if (ni == 2) bus.int_req = 1'b0; end
            if (bus.fp_done)  begin nf++; if (nf == 2) bus.fp_req  = 1'b0; end
        end
        bus.int_req = 1'b0;
        bus.fp_req  = 1'b0;
        chk("pair_int_count", ni, 2);
        chk("pair_fp_count",  nf, 2);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset during an integer load's BUSY phase aborts without a pulse
        @(negedge clk);
        bus.int_req = 1'b1; bus.int_wen = 1'b0; bus.int_addr = 32'h0000_0044;
        use_fn = 1'b0;
        bus.mem_busy = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_mem_ren", {31'b0, bus.mem_ren}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_mem_ren",   {31'b0, bus.mem_ren},  32'd0);
        chk("abort_mem_addr",  bus.mem_addr, 32'h0);
        chk("abort_int_done",  {31'b0, bus.int_done}, 32'd0);
        chk("abort_int_err",   {31'b0, bus.int_err},  32'd0);
        chk("abort_int_rdata", bus.int_rdata, 32'h0);
        rst_n = 1'b1;
        bus.int_req = 1'b0;
        bus.mem_busy = 1'b0;
        run_vec(vecs[3]);
        run_vec(vecs[0]);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
